tick_sched: RTL and testbench

- Programmable tick scheduler for the digital-clock datapath.
- Replaces free-running fixed dividers with one controlled prescaler.
- Emits single-cycle enable pulses (tick, tick_sec) and a legacy square wave (clk_half).
- Has run, pause and stop control and a guarded divide-value load, so the display scan and time counter share one timebase.

---
 rtl/tick_sched.sv | 155 +++++++++++++++
 tb/tb_tick_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
// ---------------------------------------------------------------------------
// tick_sched -- programmable tick scheduler for the digital-clock datapath.
//
// One controlled prescaler produces a single-cycle enable (tick) every
// div_reg+1 running cycles, a per-second enable (tick_sec) every SEC_TICKS
// ticks, and a legacy square wave (clk_half) that toggles on every tick.
// Run / pause / stop control plus a divide-value load that is refused
// while running.
//
// Ports:
//   clk       system clock (50 MHz)
//   rst_n     asynchronous active-low reset
//   start     level command: run, or resume from pause
//   stop      level command: pause, or stop when already paused (wins over start)
//   cfg_load  load strobe for cfg_div (accepted in IDLE/HOLD only)
//   cfg_div   new divide value
//   tick      one-cycle enable every div_reg+1 running cycles
//   tick_sec  one-cycle enable every SEC_TICKS ticks, coincident with tick
//   clk_half  toggles on every tick
//   running   high in RUN
//   paused    high in HOLD
//   cfg_err   one-cycle pulse when cfg_load arrives in RUN
// ---------------------------------------------------------------------------
module tick_sched #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 24999,
    parameter int SEC_TICKS   = 2000,
    parameter int SEC_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             tick,
    output logic             tick_sec,
    output logic             clk_half,
    output logic             running,
    output logic             paused,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_DEFAULT);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_TICKS - 1);

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_reg, div_nx;
    logic [DIV_W-1:0]   pre_cnt, pre_nx;
    logic [SEC_W-1:0]   sec_cnt, sec_nx;
    logic               tick_nx, tick_sec_nx, half_nx, err_nx;

    // Next state: stop always has priority over start.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!stop && start) state_nx = RUN;
            RUN:     if (stop)           state_nx = HOLD;
            HOLD: begin
                if (stop)       state_nx = IDLE;
                else if (start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath next values. Pulses default low, so leaving RUN or sitting
    // in IDLE/HOLD never emits tick or tick_sec.
    always_comb begin
        div_nx      = div_reg;
        pre_nx      = pre_cnt;
        sec_nx      = sec_cnt;
        half_nx     = clk_half;
        tick_nx     = 1'b0;
        tick_sec_nx = 1'b0;
        err_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_load) begin
                    div_nx = cfg_div;
                    pre_nx = '0;
                end
                if (state_nx == RUN) begin
                    pre_nx = '0;
                    sec_nx = '0;
                end
            end
            RUN: begin
                err_nx = cfg_load;
                // The stop edge freezes the counters; resume continues from them.
                if (!stop) begin
                    if (pre_cnt == div_reg) begin
                        pre_nx  = '0;
                        tick_nx = 1'b1;
                        half_nx = ~clk_half;
                        if (sec_cnt == SEC_LAST) begin
                            sec_nx      = '0;
                            tick_sec_nx = 1'b1;
                        end else begin
                            sec_nx = sec_cnt + SEC_W'(1);
                        end
                    end else begin
                        pre_nx = pre_cnt + DIV_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cfg_load) begin
                    div_nx = cfg_div;
                    pre_nx = '0;
                end
                if (stop) begin
                    pre_nx  = '0;
                    sec_nx  = '0;
                    half_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_reg  <= DIV_RST;
            pre_cnt  <= '0;
            sec_cnt  <= '0;
            tick     <= 1'b0;
            tick_sec <= 1'b0;
            clk_half <= 1'b0;
            running  <= 1'b0;
            paused   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            div_reg  <= div_nx;
            pre_cnt  <= pre_nx;
            sec_cnt  <= sec_nx;
            tick     <= tick_nx;
            tick_sec <= tick_sec_nx;
            clk_half <= half_nx;
            // Decoded from the next state so the flags line up with state.
            running  <= (state_nx == RUN);
            paused   <= (state_nx == HOLD);
            cfg_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
module tb_tick_sched;

    localparam int DIV_W = 16;
    localparam int SECT  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, cfg_load;
    logic [DIV_W-1:0] cfg_div;
    logic             tick, tick_sec, clk_half, running, paused, cfg_err;

    int checks = 0;
    int errors = 0;

    tick_sched #(.DIV_W(DIV_W), .DIV_DEFAULT(24999), .SEC_TICKS(SECT), .SEC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_load(cfg_load), .cfg_div(cfg_div),
        .tick(tick), .tick_sec(tick_sec), .clk_half(clk_half),
        .running(running), .paused(paused), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: mode, divide value, cycles elapsed in the current
    // tick period, ticks since the second counter was cleared, and outputs.
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
    int mode, mdiv, elapsed, nticks;
    bit m_tick, m_sec, m_half, m_err;

    task automatic m_reset();
        mode = M_IDLE; mdiv = 24999; elapsed = 0; nticks = 0;
        m_tick = 0; m_sec = 0; m_half = 0; m_err = 0;
    endtask

    task automatic m_edge(input bit s, input bit p, input bit l, input int d);
        m_tick = 0; m_sec = 0;
        m_err  = l && (mode == M_RUN);
        if (mode == M_RUN) begin
            if (p) mode = M_HOLD;
            else begin
                elapsed++;
                if (elapsed == mdiv + 1) begin
                    elapsed = 0;
                    nticks++;
                    m_tick = 1;
                    m_sec  = (nticks % SECT) == 0;
                    m_half = !m_half;
                end
            end
        end else begin
            if (l) begin mdiv = d; elapsed = 0; end
            if (mode == M_IDLE) begin
                if (!p && s) begin mode = M_RUN; elapsed = 0; nticks = 0; end
            end else begin
                if (p) begin mode = M_IDLE; elapsed = 0; nticks = 0; m_half = 0; end
                else if (s) mode = M_RUN;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".tick"},     tick,     m_tick);
        chk({tag, ".tick_sec"}, tick_sec, m_sec);
        chk({tag, ".clk_half"}, clk_half, m_half);
        chk({tag, ".running"},  running,  mode == M_RUN);
        chk({tag, ".paused"},   paused,   mode == M_HOLD);
        chk({tag, ".cfg_err"},  cfg_err,  m_err);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input bit s, input bit p, input bit l, input int d);
        start = s; stop = p; cfg_load = l; cfg_div = DIV_W'(d);
        @(posedge clk);
        m_edge(s, p, l, d);
        #1;
        chk_outputs("step");
        start = 0; stop = 0; cfg_load = 0; cfg_div = '0;
    endtask

    task automatic run_until_tick(input int bound, output int n);
        n = 0;
        do begin
            step(0, 0, 0, 0);
            n++;
        end while (!tick && n < bound);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".tick"},     tick,     0);
        chk({tag, ".tick_sec"}, tick_sec, 0);
        chk({tag, ".clk_half"}, clk_half, 0);
        chk({tag, ".running"},  running,  0);
        chk({tag, ".paused"},   paused,   0);
        chk({tag, ".cfg_err"},  cfg_err,  0);
    endtask

    initial begin
        int n, cnt, nsec;
        bit s, p, l;
        rst_n = 0; start = 0; stop = 0; cfg_load = 0; cfg_div = '0;
        m_reset();
        #3;
        chk_all_zero("reset");
        #10;
        rst_n = 1;

        // Default divide: first tick 25000 edges after start.
        step(1, 0, 0, 0);
        run_until_tick(25010, n);
        chk("default_first_tick", n, 25000);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        // div=3: tick every 4, tick_sec every 16 cycles, clk_half period 8.
        step(0, 0, 1, 3);
        step(1, 0, 0, 0);
        run_until_tick(10, n);
        chk("div3_first_tick", n, 4);
        nsec = 0;
        for (int i = 0; i < 3; i++) begin
            run_until_tick(10, n);
            chk("div3_period", n, 4);
            if (tick_sec) nsec++;
        end
        chk("div3_sec_on_4th_tick", nsec, 1);

        // Pause at pre_cnt=2, hold 20 cycles, resume: tick 2 edges later.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            if (tick) cnt++;
        end
        chk("hold_no_tick", cnt, 0);
        chk("hold_paused", paused, 1);
        step(1, 0, 0, 0);
        run_until_tick(10, n);
        chk("resume_tick", n, 2);

        // start+stop together.
        step(1, 1, 0, 0);
        chk("both_run_to_hold", paused, 1);
        step(1, 1, 0, 0);
        chk("both_hold_to_idle_half", clk_half, 0);
        chk("both_hold_to_idle_run", running, 0);
        step(1, 1, 0, 0);
        chk("both_idle_stays", running, 0);
        step(1, 0, 0, 0);
        run_until_tick(10, n);
        chk("after_idle_first_tick", n, 4);

        // Load in RUN is refused; load in HOLD takes effect after resume.
        step(0, 0, 1, 9);
        chk("run_load_err", cfg_err, 1);
        step(0, 0, 0, 0);
        chk("run_load_err_one_cycle", cfg_err, 0);
        run_until_tick(12, n);
        run_until_tick(12, n);
        chk("run_load_period_kept", n, 4);
        step(0, 1, 0, 0);
        step(0, 0, 1, 9);
        chk("hold_load_no_err", cfg_err, 0);
        step(1, 0, 0, 0);
        run_until_tick(15, n);
        chk("hold_load_first", n, 10);
        run_until_tick(15, n);
        chk("hold_load_period", n, 10);

        // div=0: tick on every RUN cycle.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0);
            if (tick) cnt++;
        end
        chk("div0_every_cycle", cnt, 6);

        // Randomized control traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 11) == 0);
            step(s, p, l, int'($urandom_range(0, 6)));
        end

        // Async reset while RUN with tick high.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 3);
        step(1, 0, 0, 0);
        run_until_tick(10, n);
        chk("pre_reset_tick", tick, 1);
        rst_n = 0;
        m_reset();
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (tick || running) cnt++;
        end
        chk("post_reset_idle", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
